shift_seq: RTL
==============

# shift_seq

Multicycle 16-bit shift/rotate sequencer for the execute stage. It accepts one shift request through a valid/ready handshake and applies a count of 0–15 as successive power-of-two stages: 8, then 4, 2, 1, one stage per cycle over a single shared stage datapath. It then holds the result behind an output valid/ready handshake. It replaces a fully unrolled four-stage barrel shifter where area matters more than latency.

## Interface
- Parameters: none. Data width is fixed at 16 bits; count width at 4 bits.
- `clk` in 1 — single clock; all state updates on the rising edge.
- `rst_n` in 1 — asynchronous, active-low reset.
- `in_valid` in 1 — request present.
- `in_ready` out 1 — block can accept a request.
- `in_data` in 16 — operand.
- `in_cnt` in 4 — shift amount, 0–15.
- `in_op` in 2 — operation:
  - 00: rotate left
  - 01: shift left logical
  - 10: rotate right
  - 11: shift right logical
- `out_valid` out 1 — result available.
- `out_ready` in 1 — consumer takes the result.
- `out_data` out 16 — result.
- `busy` out 1 — high whenever state ≠ IDLE.

## Operation
- **State registers:** `state` ∈ {IDLE, RUN, DONE}, `work[15:0]`, `cnt_q[3:0]`, `op_q[1:0]`, `idx[1:0]` (current stage is 2^idx).
- **IDLE:**
  - `in_ready`=1.
  - On `in_valid`&`in_ready`: `work`←`in_data`, `cnt_q`←`in_cnt`, `op_q`←`in_op`, `idx`←3, next state RUN.
- **RUN:** each cycle, if `cnt_q[idx]`=1, `work`←stage(`work`, 2^idx, `op_q`); otherwise `work` is unchanged.
  - When `idx`=0: next state DONE.
  - Otherwise `idx` is decremented.
- **Stage by k:**
  - Rotate left: {w[15-k:0], w[15:16-k]}
  - Shift left logical: {w[15-k:0], k'b0}
  - Rotate right: {w[k-1:0], w[15:k]}
  - Shift right logical: {k'b0, w[15:k]}
- **DONE:**
  - `out_valid`=1, `out_data`=`work`.
  - On `out_ready`: next state IDLE.
  - While `out_ready`=0, `out_valid` and `out_data` hold stable.
- **Ready and busy:**
  - `in_ready`=0 in RUN and DONE; `in_valid` is ignored there, with no capture and no queuing.
  - No new request is accepted in the same cycle as the DONE→IDLE handshake; `in_ready` rises the cycle after.
- **Count zero:** `cnt`=0 produces `out_data`=`in_data` for every op.
- **Result composition:** the result equals the single-step operation by `cnt`. Logical shifts zero-fill; rotates wrap.

## Timing
- **Reset values:** `state`=IDLE, `in_ready`=1, `out_valid`=0, `out_data`=0x0000, `busy`=0. `work`, `cnt_q`, `op_q` and `idx` are all cleared.
- **No capture during reset:** while `rst_n`=0 nothing is captured, regardless of `in_valid`.
- **Reset mid-operation:** asserting `rst_n` in RUN or DONE immediately returns the block to reset values. The in-flight result is discarded, and no `out_valid` pulse is produced for it.
- **Latency (macro undefined):**
  - Acceptance edge E0.
  - Stages 8, 4, 2, 1 are applied at edges E1–E4.
  - `out_valid` is high starting after E4. Fixed latency is 4 cycles for every count.
- **Throughput:** at best one result per 6 cycles, i.e. accept + 4 RUN + DONE handshake.
- **Output backpressure:** unbounded; no timeout.
- **Control outputs:** `in_ready`, `out_valid` and `busy` are decoded from registered state only, with no combinational path from inputs.
- **Output data:** `out_data` is driven from the `work` register.

## Configuration
- **`SHIFT_SEQ_SKIP_EN` undefined:** behaviour exactly as above, with fixed 4-cycle latency.
- **`SHIFT_SEQ_SKIP_EN` defined:** RUN visits only stages whose count bit is 1.
  - On acceptance, `idx`←highest set bit of `in_cnt`.
  - In RUN, `idx`←next lower set bit; if none remains, next state DONE.
  - If `in_cnt`=0, the block goes directly IDLE→DONE at E0, and `out_valid` is high after E0.
  - Latency equals popcount(`in_cnt`) edges after E0; minimum 0, maximum 4.
  - Results are identical to the macro-undefined build for all inputs.

## Test plan
- **Rotate left:** `in_data`=0x1234, `in_cnt`=4, `in_op`=00 → `out_data`=0x2341, with `out_valid` rising exactly 4 edges after acceptance.
- **Shifts and rotate right:**
  - `in_data`=0x8001, `in_cnt`=15, op 01 → 0x8000.
  - Same operand, `in_cnt`=1, op 11 → 0x4000.
  - Same operand, `in_cnt`=1, op 10 → 0xC000.
- **Backpressure:** result 0xABCD pending in DONE, `out_ready` low for 3 cycles, `in_valid` high with new data.
  - `out_valid`=1 and `out_data`=0xABCD stay stable throughout; `in_ready`=0; nothing is captured.
  - `out_ready`=1 → IDLE next cycle, `in_ready`=1.
- **Reset mid-RUN:** pulse `rst_n` low during the second RUN cycle.
  - `out_valid`=0, `out_data`=0x0000 and `busy`=0 immediately.
  - A following request 0x00FF, cnt 8, op 11 returns 0x0000.
- **Count zero and full sweep:** `in_cnt`=0 for each op with 0x5A3C → 0x5A3C. Also an exhaustive count sweep 0–15 × 4 ops compared against a reference model.
- **`SHIFT_SEQ_SKIP_EN` latency:**
  - `in_cnt`=0 → `out_valid` after E0.
  - `in_cnt`=9 → after E2.
  - `in_cnt`=15 → after E4.
  - Data matches the non-skip build.

Source files
------------

// File: rtl/shift_seq.sv
// Multicycle 16-bit shift/rotate sequencer: one power-of-two stage per cycle (8,4,2,1).
// Define SHIFT_SEQ_SKIP_EN to visit only the stages whose count bit is set.
module shift_seq (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_data,
   input  logic [3:0]  in_cnt,
   input  logic [1:0]  in_op,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_data,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [1:0] OP_ROL = 2'b00;
   localparam logic [1:0] OP_SHL = 2'b01;
   localparam logic [1:0] OP_ROR = 2'b10;
   localparam logic [1:0] OP_SHR = 2'b11;

   state_t      state, state_d;
   logic [15:0] work, work_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [1:0]  op_q, op_d;
   logic [1:0]  idx, idx_d;

   // One shared stage: shift or rotate w by 2^i.
   function automatic logic [15:0] stage(input logic [15:0] w, input logic [1:0] i,
                                         input logic [1:0] op);
      logic [4:0]  k;
      logic [15:0] r;
      k = 5'd1 << i;
      case (op)
         OP_ROL:  r = (w << k) | (w >> (5'd16 - k));
         OP_SHL:  r = w << k;
         OP_ROR:  r = (w >> k) | (w << (5'd16 - k));
         default: r = w >> k;
      endcase
      return r;
   endfunction

`ifdef SHIFT_SEQ_SKIP_EN
   function automatic logic [1:0] hi_bit(input logic [3:0] c);
      if (c[3])      return 2'd3;
      else if (c[2]) return 2'd2;
      else if (c[1]) return 2'd1;
      else           return 2'd0;
   endfunction

   logic [3:0] lower;
`endif

   always_comb begin
      // NOTE: every combinational output gets a default first so no path infers a latch.
      state_d = state;
      work_d  = work;
      cnt_d   = cnt_q;
      op_d    = op_q;
      idx_d   = idx;
`ifdef SHIFT_SEQ_SKIP_EN
      lower   = cnt_q & ((4'b1 << idx) - 4'd1);
`endif
      case (state)
         IDLE: begin
            if (in_valid) begin
               work_d = in_data;
               cnt_d  = in_cnt;
               op_d   = in_op;
`ifdef SHIFT_SEQ_SKIP_EN
               idx_d   = hi_bit(in_cnt);
               state_d = (in_cnt == 4'd0) ? DONE : RUN;
`else
               idx_d   = 2'd3;
               state_d = RUN;
`endif
            end
         end
         RUN: begin
            if (cnt_q[idx]) work_d = stage(work, idx, op_q);
`ifdef SHIFT_SEQ_SKIP_EN
            if (lower == 4'd0) state_d = DONE;
            else               idx_d   = hi_bit(lower);
`else
            if (idx == 2'd0) state_d = DONE;
            else             idx_d   = idx - 2'd1;
`endif
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         work  <= '0;
         cnt_q <= '0;
         op_q  <= '0;
         idx   <= '0;
      end else begin
         state <= state_d;
         work  <= work_d;
         cnt_q <= cnt_d;
         op_q  <= op_d;
         idx   <= idx_d;
      end
   end

   // Control outputs decode registered state only.
   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);
   assign out_data  = work;

endmodule
